// File: rtl/debug_cmd_sysclk_bridge_if.sv
// Command bus between the tck-side capture logic, the sysclk bridge and its CPU-side consumer.
interface debug_cmd_sysclk_bridge_if #(
    parameter int unsigned SR_WIDTH  = 38,
    parameter int unsigned IR_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH = 8
);
    localparam int unsigned NCH = 2 ** IR_WIDTH;

    logic [SR_WIDTH-1:0]  sr_in;
    logic [IR_WIDTH-1:0]  ir_in;
    logic                 udr_toggle;
    logic                 cmd_ready;
    logic                 overrun_clr;
    logic [SR_WIDTH-1:0]  jdo;
    logic [IR_WIDTH-1:0]  ir_q;
    logic [NCH-1:0]       take_action;
    logic [NCH-1:0]       take_no_action;
    logic                 busy;
    logic                 overrun;
    logic [CNT_WIDTH-1:0] cmd_count;

    modport master (
        output sr_in, ir_in, udr_toggle, cmd_ready, overrun_clr,
        input  jdo, ir_q, take_action, take_no_action, busy, overrun, cmd_count
    );

    modport slave (
        input  sr_in, ir_in, udr_toggle, cmd_ready, overrun_clr,
        output jdo, ir_q, take_action, take_no_action, busy, overrun, cmd_count
    );
endinterface

// File: rtl/debug_cmd_sysclk_bridge.sv
// Sysclk-side debug command bridge: captures tck-domain SR/IR on each update-DR toggle,
// holds the command until the consumer is ready, then issues one per-channel pulse.
module debug_cmd_sysclk_bridge #(
    parameter int unsigned                SR_WIDTH    = 38,
    parameter int unsigned                IR_WIDTH    = 2,
    parameter int unsigned                SYNC_STAGES = 2,
    parameter logic [(2**IR_WIDTH)-1:0]   CH_ENABLE   = '1,
    parameter int unsigned                CNT_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    debug_cmd_sysclk_bridge_if.slave    bus
);
    localparam int unsigned NCH    = 2 ** IR_WIDTH;
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        IDLE    = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t               state;
    logic [WARM_W-1:0]    warm_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 prev_q;
    logic                 sync_out_c;
    logic                 event_c;

    logic [SR_WIDTH-1:0]  jdo_q;
    logic [IR_WIDTH-1:0]  ir_q_q;
    logic [NCH-1:0]       take_action_q;
    logic [NCH-1:0]       take_no_action_q;
    logic                 busy_q;
    logic                 overrun_q;
    logic [CNT_WIDTH-1:0] cmd_count_q;

    // Toggle synchroniser; an edge of the synchronised level marks one update-DR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.udr_toggle};
            prev_q <= sync_out_c;
        end
    end

    assign sync_out_c = sync_q[SYNC_STAGES-1];
    assign event_c    = sync_out_c ^ prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= WARMUP;
            warm_cnt         <= '0;
            jdo_q            <= '0;
            ir_q_q           <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            busy_q           <= 1'b0;
            overrun_q        <= 1'b0;
            cmd_count_q      <= '0;
        end else begin
            take_action_q    <= '0;
            take_no_action_q <= '0;
            // Clear first so a same-edge overrun set below takes priority.
            if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state)
                WARMUP: begin
                    // Let the synchroniser settle so a reset-time toggle level is not seen as an update.
                    if (warm_cnt == WARM_W'(SYNC_STAGES)) begin
                        state <= IDLE;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                IDLE: begin
                    if (event_c) begin
                        jdo_q  <= bus.sr_in;
                        ir_q_q <= bus.ir_in;
                        busy_q <= 1'b1;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    // The issuing edge still counts as busy, so any event here is an overrun.
                    if (event_c) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.cmd_ready) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (CH_ENABLE[ir_q_q]) begin
                            if (jdo_q[SR_WIDTH-1]) begin
                                take_action_q <= NCH'(1) << ir_q_q;
                            end else begin
                                take_no_action_q <= NCH'(1) << ir_q_q;
                            end
                            cmd_count_q <= cmd_count_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= WARMUP;
                end
            endcase
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.ir_q           = ir_q_q;
    assign bus.take_action    = take_action_q;
    assign bus.take_no_action = take_no_action_q;
    assign bus.busy           = busy_q;
    assign bus.overrun        = overrun_q;
    assign bus.cmd_count      = cmd_count_q;
endmodule

// File: tb/tb_debug_cmd_sysclk_bridge.sv
// Scoreboard bench for debug_cmd_sysclk_bridge: stimulus pushes expected pulses, a monitor pops and compares.
module tb_debug_cmd_sysclk_bridge;
    localparam int unsigned SR = 38;
    localparam int unsigned IR = 2;
    localparam int unsigned SS = 2;
    localparam int unsigned CW = 2;
    localparam logic [3:0]  CHE = 4'b1011;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    debug_cmd_sysclk_bridge_if #(.SR_WIDTH(SR), .IR_WIDTH(IR), .CNT_WIDTH(CW)) bus ();

    debug_cmd_sysclk_bridge #(
        .SR_WIDTH(SR), .IR_WIDTH(IR), .SYNC_STAGES(SS), .CH_ENABLE(CHE), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic          act;
        logic [IR-1:0] ch;
        logic [SR-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          expq[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] mcnt = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard entry for a command that should eventually be issued.
    task automatic expect_cmd(input logic [SR-1:0] d, input logic [IR-1:0] ch);
        exp_t e;
        if (CHE[ch]) begin
            mcnt     = mcnt + CW'(1);
            e.act    = d[SR-1];
            e.ch     = ch;
            e.data   = d;
            e.cnt    = mcnt;
            expq.push_back(e);
        end
    endtask

    task automatic send(input logic [SR-1:0] d, input logic [IR-1:0] ch);
        bus.sr_in      = d;
        bus.ir_in      = ch;
        bus.udr_toggle = ~bus.udr_toggle;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.take_action != '0 || bus.take_no_action != '0) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: action=%b no_action=%b expected none (t=%0t)",
                         bus.take_action, bus.take_no_action, $time);
            end else begin
                mon_e = expq.pop_front();
                check("pulse_onehot", 64'($countones({bus.take_action, bus.take_no_action})), 64'd1);
                check("pulse_take_action", 64'(bus.take_action),
                      mon_e.act ? 64'(4'b0001 << mon_e.ch) : 64'd0);
                check("pulse_take_no_action", 64'(bus.take_no_action),
                      mon_e.act ? 64'd0 : 64'(4'b0001 << mon_e.ch));
                check("pulse_jdo", 64'(bus.jdo), 64'(mon_e.data));
                check("pulse_ir_q", 64'(bus.ir_q), 64'(mon_e.ch));
                check("pulse_cmd_count", 64'(bus.cmd_count), 64'(mon_e.cnt));
            end
        end
    end

    logic [SR-1:0] d;
    logic [IR-1:0] wch [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    logic          flag;

    initial begin
        bus.sr_in       = '0;
        bus.ir_in       = '0;
        bus.udr_toggle  = 1'b1;
        bus.cmd_ready   = 1'b0;
        bus.overrun_clr = 1'b0;
        cyc(3);

        @(negedge clk);
        check("rst_jdo", 64'(bus.jdo), 64'd0);
        check("rst_ir_q", 64'(bus.ir_q), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        check("rst_cmd_count", 64'(bus.cmd_count), 64'd0);
        check("rst_pulses", 64'({bus.take_action, bus.take_no_action}), 64'd0);

        // Warm-up: toggle held at 1 through reset release must not create a command.
        @(posedge clk); #1;
        reset_n       = 1'b1;
        bus.cmd_ready = 1'b1;
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy) flag = 1'b1;
        end
        check("warmup_busy_seen", 64'(flag), 64'd0);
        check("warmup_cmd_count", 64'(bus.cmd_count), 64'd0);
        cyc(1);

        // Basic action on channel 1 with exact latency.
        d = 38'h20_0000_00AB;
        expect_cmd(d, 2'd1);
        send(d, 2'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("basic_busy_after_capture", 64'(bus.busy), 64'd1);
        check("basic_jdo", 64'(bus.jdo), 64'(d));
        check("basic_ir_q", 64'(bus.ir_q), 64'd1);
        check("basic_no_early_pulse", 64'(bus.take_action), 64'd0);
        @(negedge clk);
        check("basic_take_action_e0p3", 64'(bus.take_action), 64'b0010);
        check("basic_busy_cleared", 64'(bus.busy), 64'd0);
        check("basic_cmd_count", 64'(bus.cmd_count), 64'd1);
        @(negedge clk);
        check("basic_pulse_one_cycle", 64'(bus.take_action), 64'd0);
        cyc(2);

        // No-action on channel 3 with a 10-cycle consumer stall.
        bus.cmd_ready = 1'b0;
        d = 38'h15_5555_1234;
        expect_cmd(d, 2'd3);
        send(d, 2'd3);
        cyc(5);
        flag = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.busy) flag = 1'b0;
        end
        check("stall_busy_held", 64'(flag), 64'd1);
        check("stall_jdo_held", 64'(bus.jdo), 64'(d));
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_take_no_action", 64'(bus.take_no_action), 64'b1000);
        check("stall_busy_dropped", 64'(bus.busy), 64'd0);
        cyc(2);

        // Overrun: second update while pending is discarded.
        bus.cmd_ready = 1'b0;
        d = 38'h2A_AAAA_5555;
        expect_cmd(d, 2'd0);
        send(d, 2'd0);
        cyc(8);
        send(38'h0B_BBBB_0001, 2'd1);
        cyc(6);
        @(negedge clk);
        check("ovr_flag", 64'(bus.overrun), 64'd1);
        check("ovr_jdo_kept", 64'(bus.jdo), 64'(d));
        check("ovr_ir_q_kept", 64'(bus.ir_q), 64'd0);
        check("ovr_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        cyc(3);
        check("ovr_sticky", 64'(bus.overrun), 64'd1);
        check("ovr_busy_after_issue", 64'(bus.busy), 64'd0);

        // Clear coincident with a new overrun: set wins.
        bus.cmd_ready = 1'b0;
        d = 38'h3C_0000_00C3;
        expect_cmd(d, 2'd1);
        send(d, 2'd1);
        cyc(6);
        send(38'h01_0000_0D0D, 2'd3);
        cyc(2);
        bus.overrun_clr = 1'b1;
        cyc(1);
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_set_beats_clr", 64'(bus.overrun), 64'd1);
        cyc(1);
        bus.overrun_clr = 1'b1;
        cyc(1);
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_clr_alone", 64'(bus.overrun), 64'd0);
        check("ovr_pending_jdo", 64'(bus.jdo), 64'(d));
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        cyc(3);

        // Disabled channel 2: dropped with no pulse and no count.
        bus.cmd_ready = 1'b0;
        d = 38'h20_0000_0E0E;
        expect_cmd(d, 2'd2);
        send(d, 2'd2);
        cyc(5);
        @(negedge clk);
        check("dis_busy", 64'(bus.busy), 64'd1);
        check("dis_ir_q", 64'(bus.ir_q), 64'd2);
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("dis_busy_cleared", 64'(bus.busy), 64'd0);
        check("dis_cmd_count", 64'(bus.cmd_count), 64'(mcnt));
        cyc(3);

        // Counter wrap: five more issued commands.
        for (int i = 0; i < 5; i++) begin
            d = ((i % 2) == 0 ? 38'h20_0000_0000 : 38'h0) | 38'(i + 16);
            expect_cmd(d, wch[i]);
            send(d, wch[i]);
            cyc(8);
        end
        check("wrap_cmd_count", 64'(bus.cmd_count), 64'd1);

        // Reset while pending clears everything immediately.
        bus.cmd_ready = 1'b0;
        d = 38'h3F_FFFF_FFFF;
        send(d, 2'd1);
        cyc(5);
        @(negedge clk);
        check("rstp_busy_before", 64'(bus.busy), 64'd1);
        check("rstp_jdo_before", 64'(bus.jdo), 64'(d));
        #2;
        reset_n = 1'b0;
        #1;
        check("rstp_busy_async", 64'(bus.busy), 64'd0);
        check("rstp_jdo_async", 64'(bus.jdo), 64'd0);
        check("rstp_ir_q_async", 64'(bus.ir_q), 64'd0);
        check("rstp_cmd_count_async", 64'(bus.cmd_count), 64'd0);
        mcnt = '0;
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(20);
        check("rstp_busy_after", 64'(bus.busy), 64'd0);
        check("rstp_cmd_count_after", 64'(bus.cmd_count), 64'd0);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
